spi_target_port: RTL and testbench
==================================

Name: spi_target_port

Overview:
- SPI target (slave) endpoint: the responder side of the SPI master already present in the slurm16 memory-mapped peripheral set.
- Receives 16-bit words from an external master on SCK_I/SSb_I/SI and returns words on SO.
- Sits behind the memory controller as a 4-register peripheral.
- SPI mode 0 only: sample on the rising edge of SCK, shift on the falling edge, MSB first. All SPI inputs are oversampled in the CLK domain.

Parameters:
- WORD_BITS, 16, SPI word length and bus data width.
- SYNC_STAGES, 2, synchronizer flops on each SPI input (minimum 2).

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  reset; synchronous, active-high.
- ADDR  in  2  register select: 0 TXDATA, 1 RXDATA, 2 STATUS, 3 CONTROL.
- DATA_IN  in  16  bus write data.
- DATA_OUT  out  16  bus read data; registered.
- WR  in  1  bus write strobe, one cycle.
- RD  in  1  bus read strobe, one cycle.
- SCK_I  in  1  SPI clock from the master; asynchronous.
- SSb_I  in  1  SPI select, active low; asynchronous.
- SI  in  1  SPI data in (master out).
- SO  out  1  SPI data out (master in).
- SO_OE  out  1  SO output enable.
- IRQ  out  1  level interrupt.

Behaviour:
- Reset values:
  - DATA_OUT=0, SO=1, SO_OE=0, IRQ=0.
  - All flags and CONTROL cleared; tx_hold=0xFFFF; bit counter=0.
  - Synchronizer flops are set to idle levels: SCK=0, SSb=1, SI=1.
- RST mid-frame aborts the frame silently: no flags are set and the partial word is dropped.
- Input conditioning:
  - SCK_I, SSb_I and SI each pass through SYNC_STAGES flops, plus one history flop for edge detect.
  - SCK_I frequency is at most CLK/8.
  - Latency from a pin edge to the internal event is SYNC_STAGES+1 cycles.
- Frame start (ss_fall while CONTROL.EN=1):
  - bitcnt=0.
  - If tx_valid: tx_shift=tx_hold and tx_valid clears.
  - Otherwise: tx_shift=0xFFFF and UNDERRUN sets.
  - SO=tx_shift[15] in the same cycle.
- SO_OE=1 while EN and the synced SSb is low; otherwise SO_OE=0 and SO=1.
- Rising sck event while selected:
  - rx_shift={rx_shift[14:0],SI_sync}; bitcnt++.
- Word complete (bitcnt reaches 16 on a rising sck event):
  - If rx_valid is already 1: OVERRUN sets, the new word is dropped and rx_hold is unchanged.
  - Otherwise: rx_hold gets the new word and rx_valid sets.
  - bitcnt=0.
- Falling sck event while selected:
  - If bitcnt==0 and a word has completed: reload tx_shift from tx_hold, with the same underrun rule as frame start.
  - Otherwise: shift tx_shift left, filling with 1.
  - SO=new tx_shift[15].
- ss_rise with bitcnt!=0: ABORT sets; partial rx discarded; bitcnt=0. ss_rise with bitcnt==0 is clean.
- EN=0: SPI events are ignored. Clearing EN mid-frame behaves like ss_rise.
- Bus interface (1-cycle read latency):
  - TXDATA write: tx_hold=DATA_IN, tx_valid=1. A write while tx_valid=1 overwrites the held word.
  - RXDATA read: DATA_OUT=rx_hold and rx_valid clears.
  - STATUS read: bit0 rx_valid, bit1 tx_empty (~tx_valid), bit2 OVERRUN, bit3 UNDERRUN, bit4 ABORT, bit5 ss_active; other bits 0.
  - STATUS write: write-1-to-clear on bits 2–4; other bits ignored.
  - CONTROL: read/write; bit0 EN, bit1 RXIE, bit2 TXIE.
  - Reads of TXDATA return 0.
- IRQ (registered) = (RXIE&rx_valid) | (TXIE&~tx_valid) | (RXIE&(OVERRUN|ABORT)).
- Simultaneous events:
  - RXDATA read in the same cycle as word completion: the read returns the old rx_hold, the new word loads, rx_valid stays 1, and no overrun is flagged.
  - TXDATA write in the same cycle as a tx load: the load takes the old tx_hold (or 0xFFFF with underrun); the write then lands and tx_valid=1.
  - W1C in the same cycle as a flag set: the set wins.

Decomposition:
- Package slurm16_spi_pkg:
  - register offsets TXDATA/RXDATA/STATUS/CONTROL;
  - STATUS and CONTROL bit indices;
  - idle fill constant 0xFFFF.
- Sub-module spi_input_sync:
  - parameterised synchronizer plus edge detect, outputs level/rise/fall;
  - instantiated for SCK and SSb; SI uses the level output only.

Test Plan:
- Write TXDATA=0xA55A and EN=1, then the master sends 0x1234 in mode 0 at CLK/8 → master receives 0xA55A; RXDATA reads 0x1234; STATUS shows rx_valid=1, then 0 after the read.
- Two back-to-back words in one frame with only one TX word loaded → second MISO word is 0xFFFF and UNDERRUN=1; writing 0x0008 to STATUS clears it.
- Two words received without an RXDATA read → rx_hold keeps the first word; OVERRUN=1; IRQ=1 with RXIE=1.
- SSb_I deasserts after 7 bits → ABORT=1; rx_valid stays 0; the next full frame receives correctly.
- RXDATA read in the same cycle as the 16th rising SCK event → old value returned, rx_valid remains 1, OVERRUN=0.
- RST asserted mid-frame → SO_OE=0, SO=1, DATA_OUT=0, all flags 0, tx_hold=0xFFFF on the next cycle.

Source files
------------

// File: rtl/slurm16_spi_pkg.sv
// Shared definitions for the slurm16 SPI target peripheral: register map,
// STATUS/CONTROL bit positions and the word driven when no TX data is queued.
package slurm16_spi_pkg;

  typedef enum logic [1:0] {
    REG_TXDATA  = 2'd0,
    REG_RXDATA  = 2'd1,
    REG_STATUS  = 2'd2,
    REG_CONTROL = 2'd3
  } reg_addr_e;

  // STATUS bit positions
  localparam int unsigned ST_RX_VALID  = 0;
  localparam int unsigned ST_TX_EMPTY  = 1;
  localparam int unsigned ST_OVERRUN   = 2;
  localparam int unsigned ST_UNDERRUN  = 3;
  localparam int unsigned ST_ABORT     = 4;
  localparam int unsigned ST_SS_ACTIVE = 5;

  // CONTROL bit positions
  localparam int unsigned CTL_EN   = 0;
  localparam int unsigned CTL_RXIE = 1;
  localparam int unsigned CTL_TXIE = 2;

  // Shifted out when the master clocks a word that software never supplied
  localparam logic [15:0] IDLE_FILL = 16'hFFFF;

endpackage

// File: rtl/spi_input_sync.sv
// Synchronizer for one asynchronous SPI pin plus a history flop for edge
// detection. Flops reset to the pin's idle level so reset never fakes an edge.
module spi_input_sync #(
  parameter int unsigned STAGES = 2,
  parameter logic        IDLE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              hist;

  // Shift the pin through the synchronizer and remember the previous level
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{IDLE}};
      hist  <= IDLE;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      hist  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = chain[STAGES-1] & ~hist;
  assign fall  = ~chain[STAGES-1] & hist;

endmodule

// File: rtl/spi_target_port.sv
// SPI mode-0 target endpoint behind the slurm16 memory controller.
// Four registers (TXDATA, RXDATA, STATUS, CONTROL); all SPI pins are
// oversampled in the CLK domain, so SCK must be at most CLK/8.
module spi_target_port
  import slurm16_spi_pkg::*;
#(
  parameter int unsigned WORD_BITS   = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [1:0]           ADDR,
  input  logic [WORD_BITS-1:0] DATA_IN,
  output logic [WORD_BITS-1:0] DATA_OUT,
  input  logic                 WR,
  input  logic                 RD,
  input  logic                 SCK_I,
  input  logic                 SSb_I,
  input  logic                 SI,
  output logic                 SO,
  output logic                 SO_OE,
  output logic                 IRQ
);

  localparam int unsigned          CNT_W    = $clog2(WORD_BITS);
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WORD_BITS - 1);
  // Idle fill replicated to the configured word width
  localparam logic [WORD_BITS-1:0] FILL     = {WORD_BITS{IDLE_FILL[0]}};

  // Conditioned SPI pins
  logic sck_rise, sck_fall, sck_level_unused;
  logic ss_level, ss_rise, ss_fall;
  logic si_level, si_rise_unused, si_fall_unused;

  spi_input_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sync_sck (
    .clk(CLK), .rst(RST), .din(SCK_I),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_sync_ss (
    .clk(CLK), .rst(RST), .din(SSb_I),
    .level(ss_level), .rise(ss_rise), .fall(ss_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_sync_si (
    .clk(CLK), .rst(RST), .din(SI),
    .level(si_level), .rise(si_rise_unused), .fall(si_fall_unused)
  );

  // Architectural state
  logic                 ctrl_en, ctrl_rxie, ctrl_txie;
  logic [WORD_BITS-1:0] tx_hold, tx_shift, rx_shift, rx_hold;
  logic                 tx_valid, rx_valid;
  logic [CNT_W-1:0]     bitcnt;
  logic                 word_done, ss_active;
  logic                 overrun, underrun, abort_flag;

  // Next-state values
  logic                 ctrl_en_n, ctrl_rxie_n, ctrl_txie_n;
  logic [WORD_BITS-1:0] tx_hold_n, tx_shift_n, rx_shift_n, rx_hold_n;
  logic                 tx_valid_n, rx_valid_n;
  logic [CNT_W-1:0]     bitcnt_n;
  logic                 word_done_n, ss_active_n;
  logic                 overrun_n, underrun_n, abort_n;
  logic [WORD_BITS-1:0] data_out_n;
  logic                 so_n, so_oe_n, irq_n;

  // Per-cycle helpers
  reg_addr_e            reg_sel;
  logic                 wr_tx, wr_st, wr_ctrl, rd_rx;
  logic                 frame_start, frame_end;
  logic                 tx_load;
  logic                 overrun_set, underrun_set, abort_set;
  logic [WORD_BITS-1:0] rx_word, status, ctrl_word;

  assign reg_sel     = reg_addr_e'(ADDR);
  assign wr_tx       = WR && (reg_sel == REG_TXDATA);
  assign wr_st       = WR && (reg_sel == REG_STATUS);
  assign wr_ctrl     = WR && (reg_sel == REG_CONTROL);
  assign rd_rx       = RD && (reg_sel == REG_RXDATA);
  assign frame_start = ss_fall && ctrl_en;
  // Clearing EN inside a frame ends it exactly as a deselect would
  assign frame_end   = ss_active && (ss_rise || (wr_ctrl && !DATA_IN[CTL_EN]));
  assign rx_word     = {rx_shift[WORD_BITS-2:0], si_level};

  // Register read views
  always_comb begin
    status                = '0;
    status[ST_RX_VALID]   = rx_valid;
    status[ST_TX_EMPTY]   = ~tx_valid;
    status[ST_OVERRUN]    = overrun;
    status[ST_UNDERRUN]   = underrun;
    status[ST_ABORT]      = abort_flag;
    status[ST_SS_ACTIVE]  = ss_active;
    ctrl_word             = '0;
    ctrl_word[CTL_EN]     = ctrl_en;
    ctrl_word[CTL_RXIE]   = ctrl_rxie;
    ctrl_word[CTL_TXIE]   = ctrl_txie;
  end

  // Next-state for SPI shifting and bus side effects. Ordering resolves
  // same-cycle collisions: an RXDATA read clears rx_valid before a completing
  // word may set it again, a TX load consumes the old tx_hold before a
  // TXDATA write lands, and flag sets override write-1-to-clear.
  always_comb begin
    ctrl_en_n    = ctrl_en;
    ctrl_rxie_n  = ctrl_rxie;
    ctrl_txie_n  = ctrl_txie;
    tx_hold_n    = tx_hold;
    tx_shift_n   = tx_shift;
    rx_shift_n   = rx_shift;
    rx_hold_n    = rx_hold;
    tx_valid_n   = tx_valid;
    rx_valid_n   = rx_valid;
    bitcnt_n     = bitcnt;
    word_done_n  = word_done;
    ss_active_n  = ss_active;
    tx_load      = 1'b0;
    overrun_set  = 1'b0;
    underrun_set = 1'b0;
    abort_set    = 1'b0;

    if (rd_rx) rx_valid_n = 1'b0;

    if (wr_ctrl) begin
      ctrl_en_n   = DATA_IN[CTL_EN];
      ctrl_rxie_n = DATA_IN[CTL_RXIE];
      ctrl_txie_n = DATA_IN[CTL_TXIE];
    end

    if (frame_start) begin
      ss_active_n = 1'b1;
      bitcnt_n    = '0;
      word_done_n = 1'b0;
      tx_load     = 1'b1;
    end else if (frame_end) begin
      if (bitcnt != '0) abort_set = 1'b1;
      ss_active_n = 1'b0;
      bitcnt_n    = '0;
      word_done_n = 1'b0;
    end else if (ss_active) begin
      if (sck_rise) begin
        if (bitcnt == LAST_BIT) begin
          bitcnt_n    = '0;
          word_done_n = 1'b1;
          if (rx_valid && !rd_rx) begin
            overrun_set = 1'b1;
          end else begin
            rx_hold_n  = rx_word;
            rx_valid_n = 1'b1;
          end
        end else begin
          rx_shift_n = rx_word;
          bitcnt_n   = bitcnt + 1'b1;
        end
      end else if (sck_fall) begin
        if (bitcnt == '0 && word_done) begin
          tx_load     = 1'b1;
          word_done_n = 1'b0;
        end else begin
          tx_shift_n = {tx_shift[WORD_BITS-2:0], 1'b1};
        end
      end
    end

    if (tx_load) begin
      if (tx_valid) begin
        tx_shift_n = tx_hold;
        tx_valid_n = 1'b0;
      end else begin
        tx_shift_n   = FILL;
        underrun_set = 1'b1;
      end
    end

    if (wr_tx) begin
      tx_hold_n  = DATA_IN;
      tx_valid_n = 1'b1;
    end

    overrun_n  = (overrun    & ~(wr_st & DATA_IN[ST_OVERRUN]))  | overrun_set;
    underrun_n = (underrun   & ~(wr_st & DATA_IN[ST_UNDERRUN])) | underrun_set;
    abort_n    = (abort_flag & ~(wr_st & DATA_IN[ST_ABORT]))    | abort_set;
  end

  // Registered outputs derived from the values being committed this cycle
  always_comb begin
    data_out_n = DATA_OUT;
    if (RD) begin
      unique case (reg_sel)
        REG_TXDATA:  data_out_n = '0;
        REG_RXDATA:  data_out_n = rx_hold;
        REG_STATUS:  data_out_n = status;
        REG_CONTROL: data_out_n = ctrl_word;
        default:     data_out_n = '0;
      endcase
    end
    so_oe_n = ctrl_en_n & ~ss_level;
    so_n    = so_oe_n ? tx_shift_n[WORD_BITS-1] : 1'b1;
    irq_n   = (ctrl_rxie_n & rx_valid_n) |
              (ctrl_txie_n & ~tx_valid_n) |
              (ctrl_rxie_n & (overrun_n | abort_n));
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      ctrl_en    <= 1'b0;
      ctrl_rxie  <= 1'b0;
      ctrl_txie  <= 1'b0;
      tx_hold    <= FILL;
      tx_shift   <= FILL;
      rx_shift   <= '0;
      rx_hold    <= '0;
      tx_valid   <= 1'b0;
      rx_valid   <= 1'b0;
      bitcnt     <= '0;
      word_done  <= 1'b0;
      ss_active  <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
      abort_flag <= 1'b0;
      DATA_OUT   <= '0;
      SO         <= 1'b1;
      SO_OE      <= 1'b0;
      IRQ        <= 1'b0;
    end else begin
      ctrl_en    <= ctrl_en_n;
      ctrl_rxie  <= ctrl_rxie_n;
      ctrl_txie  <= ctrl_txie_n;
      tx_hold    <= tx_hold_n;
      tx_shift   <= tx_shift_n;
      rx_shift   <= rx_shift_n;
      rx_hold    <= rx_hold_n;
      tx_valid   <= tx_valid_n;
      rx_valid   <= rx_valid_n;
      bitcnt     <= bitcnt_n;
      word_done  <= word_done_n;
      ss_active  <= ss_active_n;
      overrun    <= overrun_n;
      underrun   <= underrun_n;
      abort_flag <= abort_n;
      DATA_OUT   <= data_out_n;
      SO         <= so_n;
      SO_OE      <= so_oe_n;
      IRQ        <= irq_n;
    end
  end

endmodule

// File: tb/tb_spi_target_port.sv
// Directed bench for spi_target_port: bus accesses plus a mode-0 SPI master
// model running at CLK/8, with hand-computed expectations per scenario.
module tb_spi_target_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr;
  logic [15:0] data_in, data_out;
  logic        wr, rd;
  logic        sck, ssb, si;
  logic        so, so_oe, irq;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  spi_target_port #(.WORD_BITS(16), .SYNC_STAGES(2)) dut (
    .CLK(clk), .RST(rst), .ADDR(addr), .DATA_IN(data_in), .DATA_OUT(data_out),
    .WR(wr), .RD(rd), .SCK_I(sck), .SSb_I(ssb), .SI(si),
    .SO(so), .SO_OE(so_oe), .IRQ(irq)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; data_in = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d = data_out;
  endtask

  // Clock nbits bits MSB-first; SO is captured just before each SCK rise.
  // With rd_last, an RXDATA read is timed to coincide with the last rise event.
  task automatic spi_bits(input logic [15:0] mosi, input int nbits, input bit rd_last,
                          output logic [15:0] miso, output logic [15:0] rd_data);
    miso = '0;
    rd_data = '0;
    for (int i = 0; i < nbits; i++) begin
      si = mosi[15-i];
      repeat (4) @(negedge clk);
      miso = {miso[14:0], so};
      sck = 1'b1;
      if (rd_last && i == nbits - 1) begin
        repeat (2) @(negedge clk);
        addr = 2'd1; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        rd_data = data_out;
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [15:0] mosi, output logic [15:0] miso);
    logic [15:0] unused_rd;
    @(negedge clk);
    ssb = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(mosi, 16, 1'b0, miso, unused_rd);
    repeat (4) @(negedge clk);
    ssb = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; addr = '0; data_in = '0; wr = 1'b0; rd = 1'b0;
    sck = 1'b0; ssb = 1'b1; si = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (data_out !== 16'h0000) begin errors++; $display("FAIL reset_data_out: got %h want %h", data_out, 16'h0000); end
    vectors++; if (so !== 1'b1) begin errors++; $display("FAIL reset_so: got %b want 1", so); end
    vectors++; if (so_oe !== 1'b0) begin errors++; $display("FAIL reset_so_oe: got %b want 0", so_oe); end
    vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    rst = 1'b0;
    begin
      logic [15:0] d;
      bus_read(2'd2, d);
      vectors++; if (d !== 16'h0002) begin errors++; $display("FAIL reset_status: got %h want %h", d, 16'h0002); end
      bus_read(2'd3, d);
      vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_control: got %h want %h", d, 16'h0000); end
    end
  endtask

  task automatic test_basic;
    logic [15:0] m, d;
    bus_write(2'd0, 16'hA55A);
    bus_write(2'd3, 16'h0001);
    bus_read(2'd0, d);
    vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL txdata_read: got %h want %h", d, 16'h0000); end
    frame(16'h1234, m);
    vectors++; if (m !== 16'hA55A) begin errors++; $display("FAIL basic_miso: got %h want %h", m, 16'hA55A); end
    bus_read(2'd2, d);
    vectors++; if (d[0] !== 1'b1) begin errors++; $display("FAIL basic_rx_valid_set: got %b want 1", d[0]); end
    bus_read(2'd1, d);
    vectors++; if (d !== 16'h1234) begin errors++; $display("FAIL basic_rxdata: got %h want %h", d, 16'h1234); end
    bus_read(2'd2, d);
    vectors++; if (d[0] !== 1'b0) begin errors++; $display("FAIL basic_rx_valid_clr: got %b want 0", d[0]); end
    bus_write(2'd2, 16'h001C);
  endtask

  task automatic test_back_to_back;
    logic [15:0] m1, m2, d, unused_rd;
    bus_write(2'd0, 16'hBEEF);
    @(negedge clk);
    ssb = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(16'h0F0F, 16, 1'b0, m1, unused_rd);
    spi_bits(16'hF0F0, 16, 1'b0, m2, unused_rd);
    repeat (4) @(negedge clk);
    ssb = 1'b1;
    repeat (8) @(negedge clk);
    vectors++; if (m1 !== 16'hBEEF) begin errors++; $display("FAIL b2b_miso1: got %h want %h", m1, 16'hBEEF); end
    vectors++; if (m2 !== 16'hFFFF) begin errors++; $display("FAIL b2b_miso2: got %h want %h", m2, 16'hFFFF); end
    bus_read(2'd2, d);
    vectors++; if (d !== 16'h000F) begin errors++; $display("FAIL b2b_status: got %h want %h", d, 16'h000F); end
    bus_write(2'd2, 16'h0008);
    bus_read(2'd2, d);
    vectors++; if (d !== 16'h0007) begin errors++; $display("FAIL b2b_underrun_w1c: got %h want %h", d, 16'h0007); end
    bus_write(2'd2, 16'h0004);
    bus_read(2'd1, d);
    vectors++; if (d !== 16'h0F0F) begin errors++; $display("FAIL b2b_rx_kept: got %h want %h", d, 16'h0F0F); end
    bus_read(2'd2, d);
    vectors++; if (d !== 16'h0002) begin errors++; $display("FAIL b2b_status_clean: got %h want %h", d, 16'h0002); end
  endtask

  task automatic test_overrun_irq;
    logic [15:0] m, d;
    bus_write(2'd3, 16'h0003);
    vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b want 0", irq); end
    frame(16'h1357, m);
    frame(16'h2468, m);
    vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_overrun: got %b want 1", irq); end
    bus_read(2'd2, d);
    vectors++; if (d !== 16'h000F) begin errors++; $display("FAIL ovr_status: got %h want %h", d, 16'h000F); end
    bus_read(2'd1, d);
    vectors++; if (d !== 16'h1357) begin errors++; $display("FAIL ovr_rx_kept: got %h want %h", d, 16'h1357); end
    vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_held_by_overrun: got %b want 1", irq); end
    bus_write(2'd2, 16'h001C);
    vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b want 0", irq); end
    bus_write(2'd3, 16'h0001);
  endtask

  task automatic test_abort;
    logic [15:0] m, d, unused_rd;
    @(negedge clk);
    ssb = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(16'hABCD, 7, 1'b0, m, unused_rd);
    repeat (4) @(negedge clk);
    ssb = 1'b1;
    repeat (8) @(negedge clk);
    bus_read(2'd2, d);
    vectors++; if (d !== 16'h001A) begin errors++; $display("FAIL abort_status: got %h want %h", d, 16'h001A); end
    bus_write(2'd2, 16'h001C);
    bus_write(2'd0, 16'h5AA5);
    frame(16'hC3C3, m);
    vectors++; if (m !== 16'h5AA5) begin errors++; $display("FAIL abort_next_miso: got %h want %h", m, 16'h5AA5); end
    bus_read(2'd1, d);
    vectors++; if (d !== 16'hC3C3) begin errors++; $display("FAIL abort_next_rx: got %h want %h", d, 16'hC3C3); end
    bus_write(2'd2, 16'h001C);
  endtask

  task automatic test_read_collision;
    logic [15:0] m, d, rdd;
    frame(16'h1111, m);
    @(negedge clk);
    ssb = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(16'h2222, 16, 1'b1, m, rdd);
    repeat (4) @(negedge clk);
    ssb = 1'b1;
    repeat (8) @(negedge clk);
    vectors++; if (rdd !== 16'h1111) begin errors++; $display("FAIL coll_old_value: got %h want %h", rdd, 16'h1111); end
    bus_read(2'd2, d);
    vectors++; if ((d & 16'h0005) !== 16'h0001) begin errors++; $display("FAIL coll_valid_no_ovr: got %h want %h", d & 16'h0005, 16'h0001); end
    bus_read(2'd1, d);
    vectors++; if (d !== 16'h2222) begin errors++; $display("FAIL coll_new_word: got %h want %h", d, 16'h2222); end
    bus_write(2'd2, 16'h001C);
  endtask

  task automatic test_reset_midframe;
    logic [15:0] m, d, unused_rd;
    bus_write(2'd0, 16'h7777);
    bus_read(2'd3, d);
    vectors++; if (d !== 16'h0001) begin errors++; $display("FAIL rst_pre_control: got %h want %h", d, 16'h0001); end
    @(negedge clk);
    ssb = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(16'h00FF, 5, 1'b0, m, unused_rd);
    vectors++; if (so_oe !== 1'b1) begin errors++; $display("FAIL rst_pre_so_oe: got %b want 1", so_oe); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (so_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_so_oe: got %b want 0", so_oe); end
    vectors++; if (so !== 1'b1) begin errors++; $display("FAIL rst_mid_so: got %b want 1", so); end
    vectors++; if (data_out !== 16'h0000) begin errors++; $display("FAIL rst_mid_data_out: got %h want %h", data_out, 16'h0000); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (so_oe !== 1'b0) begin errors++; $display("FAIL rst_after_so_oe: got %b want 0", so_oe); end
    bus_read(2'd2, d);
    vectors++; if (d !== 16'h0002) begin errors++; $display("FAIL rst_after_status: got %h want %h", d, 16'h0002); end
    ssb = 1'b1;
    repeat (8) @(negedge clk);
    bus_write(2'd3, 16'h0001);
    frame(16'h0000, m);
    vectors++; if (m !== 16'hFFFF) begin errors++; $display("FAIL rst_tx_hold_fill: got %h want %h", m, 16'hFFFF); end
    bus_read(2'd2, d);
    vectors++; if (d[3] !== 1'b1) begin errors++; $display("FAIL rst_underrun: got %b want 1", d[3]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun_irq();
    test_abort();
    test_read_collision();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
